// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode constants, the ctrl_t control bundle and the bubble value
// shared by the decoder and the control pipeline.
package ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       branch_reg;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_half;
    logic       reg_write;
    logic       pcs;
    logic       halt;
  } ctrl_t;

  localparam int CW = $bits(ctrl_t);

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control bundle; an invalid
// instruction decodes to a bubble.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic          valid,
  input  logic [3:0]    opcode,
  output logic [CW-1:0] ctrl
);

  ctrl_t dec;

  // Opcode decode; every field not set for an opcode stays 0.
  always_comb begin
    dec = BUBBLE;
    if (valid) begin
      if (!opcode[3]) begin
        dec.alu_op    = opcode[2:0];
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
      end else begin
        case (opcode)
          OP_LW: begin
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
          end
          OP_SW: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
          end
          OP_LLB: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
          end
          OP_LHB: begin
            dec.alu_src   = 1'b1;
            dec.mem_half  = 1'b1;
            dec.reg_write = 1'b1;
          end
          OP_B:   dec.branch = 1'b1;
          OP_BR: begin
            dec.branch     = 1'b1;
            dec.branch_reg = 1'b1;
          end
          OP_PCS: begin
            dec.pcs       = 1'b1;
            dec.reg_write = 1'b1;
          end
          OP_HLT: dec.halt = 1'b1;
          default: dec = BUBBLE;
        endcase
      end
    end
  end

  assign ctrl = dec;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the ID opcode and carries the control bundle and
// destination index through NSTAGE pipeline registers (stage 0 = EX,
// stage NSTAGE-1 = WB), with stall, flush, load-use bubbles and sticky halt.
// Optional feature macro: CTRL_LOADUSE_EN enables load-use hazard detection.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int RW     = 4,
  parameter int NSTAGE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [3:0]           id_opcode,
  input  logic [RW-1:0]        id_rs,
  input  logic [RW-1:0]        id_rt,
  input  logic [RW-1:0]        id_rd,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic [CW-1:0]        id_ctrl,
  output logic [NSTAGE*CW-1:0] st_ctrl,
  output logic [NSTAGE*RW-1:0] st_rd,
  output logic                 hazard_stall,
  output logic                 halted
);

  ctrl_t id_bundle;
  logic  load_use;
  logic  advance;
  logic  inject_bubble;
  logic  halt_pending_q, halt_pending_d;
  logic  halted_q, halted_d;

  ctrl_decode u_decode (
    .valid  (id_valid),
    .opcode (id_opcode),
    .ctrl   (id_ctrl)
  );

  assign id_bundle = id_ctrl;

`ifdef CTRL_LOADUSE_EN
  // Load in EX whose destination (never r0) is a source of the ID instruction.
  always_comb begin
    load_use = id_valid && g_stage[0].ctrl_q.mem_read && (g_stage[0].rd_q != '0) &&
               ((g_stage[0].rd_q == id_rs) || (g_stage[0].rd_q == id_rt));
  end
`else
  logic unused_src;
  assign unused_src = ^{id_rs, id_rt};
  assign load_use   = 1'b0;
`endif

  assign hazard_stall  = load_use;
  assign advance       = !stall_in;
  assign inject_bubble = flush || load_use || halt_pending_q;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    ctrl_t         ctrl_q, ctrl_d;
    logic [RW-1:0] rd_q, rd_d;

    if (k == 0) begin : g_head
      // Stage 0 takes the decoded ID instruction or a bubble.
      always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (advance) begin
          if (inject_bubble) begin
            ctrl_d = BUBBLE;
            rd_d   = '0;
          end else begin
            ctrl_d = id_bundle;
            rd_d   = id_rd;
          end
        end
      end
    end else begin : g_tail
      // Later stages shift from the previous stage unless frozen.
      always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (advance) begin
          ctrl_d = g_stage[k-1].ctrl_q;
          rd_d   = g_stage[k-1].rd_q;
        end
      end
    end

    // Stage register; reset discards in-flight bundles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q <= BUBBLE;
        rd_q   <= '0;
      end else begin
        ctrl_q <= ctrl_d;
        rd_q   <= rd_d;
      end
    end

    assign st_ctrl[k*CW +: CW] = ctrl_q;
    assign st_rd[k*RW +: RW]   = rd_q;
  end

  // halted is set on the edge that moves the halt into WB (looking at the
  // stage before WB), so it rises together with WB halt=1.
  always_comb begin
    halt_pending_d = halt_pending_q;
    halted_d       = halted_q;
    if (advance) begin
      if (!inject_bubble && id_bundle.halt) halt_pending_d = 1'b1;
      if (g_stage[NSTAGE-2].ctrl_q.halt)    halted_d       = 1'b1;
    end
  end

  // Sticky halt flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined successor to the single-cycle opcode decoder. Decodes the 4-bit opcode in ID into a control bundle and carries that bundle, plus the destination register index, through NSTAGE downstream pipeline registers (EX, MEM, WB by default). Also handles:

- load-use hazard bubbles
- branch flush
- global stall
- a sticky halt

It sits between the fetch/decode register file read and the datapath stage muxes.

## Interface
Parameters:
- RW, 4, register index width
- NSTAGE, 3, downstream stages after ID (minimum 2); stage 0 = EX, stage NSTAGE-1 = WB

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  opcode of ID instruction
- id_rs, id_rt, id_rd  in  RW each  source and destination indices in ID
- stall_in  in  1  external freeze (memory wait)
- flush  in  1  branch taken; kill ID instruction
- id_ctrl  out  CW  combinational decode of ID (zero when !id_valid)
- st_ctrl  out  NSTAGE*CW  registered bundle per stage, stage k at [k*CW +: CW]
- st_rd  out  NSTAGE*RW  registered destination per stage
- hazard_stall  out  1  hold PC and IF/ID this cycle
- halted  out  1  sticky; halt has reached WB

## Operation
- Bundle CW = 14 bits: alu_op[2:0], reg_dst, alu_src, branch, branch_reg, mem_read, mem_to_reg, mem_write, mem_half, reg_write, pcs, halt.
- Decode:
  - 0xxx ALU: reg_dst, reg_write, alu_op = opcode[2:0]
  - 1000 LW: mem_read, mem_to_reg, alu_src, reg_write
  - 1001 SW: mem_write, alu_src
  - 1010 LLB: alu_src, reg_write
  - 1011 LHB: alu_src, mem_half, reg_write
  - 1100 B: branch
  - 1101 BR: branch, branch_reg
  - 1110 PCS: pcs, reg_write
  - 1111 HLT: halt
  - Unlisted bits are 0; alu_op is 0 for non-ALU opcodes.
- Bubble: all-zero bundle, rd = 0.
- Each cycle, priority stall_in > flush > hazard > normal:
  - stall_in: every stage register holds; hazard_stall still reflects the hazard.
  - flush: stage 0 loads a bubble; the rest shift.
  - hazard: stage 0 loads a bubble; the rest shift.
  - normal: stage 0 loads id_ctrl/id_rd; stage k loads stage k-1.
- Load-use hazard: stage 0 mem_read=1 AND st_rd[0] != 0 AND (st_rd[0]==id_rs OR st_rd[0]==id_rt) AND id_valid. Register 0 never causes a hazard.
- Halt:
  - halt_pending sets when a halt bundle enters stage 0.
  - While halt_pending is set, stage 0 always loads bubbles.
  - halted sets when stage NSTAGE-1 halt=1 (and not stalled).
  - Both clear only on reset.
  - A halt in ID that is flushed never sets halt_pending.

## Timing
- id_ctrl: zero latency (combinational).
- Stage k output: k+1 edges after the instruction is in ID, plus stall and bubble cycles.
- hazard_stall is combinational; it asserts in the same cycle as the hazard and lasts exactly one cycle per load-use, because the bubble clears stage 0 mem_read.
- Reset (async assert, sync release):
  - all st_ctrl, st_rd = 0
  - halt_pending = 0
  - halted = 0
  - hazard_stall = 0 while id_valid = 0
- Reset mid-pipeline discards all in-flight bundles.
- Simultaneous flush + hazard: flush wins; hazard_stall still asserts, which is harmless since IF/ID is refetched.
- Halt reaching WB during stall_in: halted sets on the first non-stalled edge.

## Configuration
- CTRL_LOADUSE_EN:
  - Defined: load-use detection as above.
  - Undefined: hazard_stall is tied 0 and no bubbles are inserted for loads; software or the forwarding unit must cover it.
- Decode, flush, stall and halt behaviour are identical in both builds.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams (OP_LW=4'b1000 … OP_HLT=4'b1111)
  - the ctrl_t packed struct with field order as listed, CW = $bits(ctrl_t)
  - BUBBLE constant
- Sub-module ctrl_decode: purely combinational opcode → ctrl_t, reused by id_ctrl.
- ctrl_pipe instantiates one ctrl_decode plus a generate loop of NSTAGE stage registers.

## Test plan
- Reset, then issue ADD (0000, rd=3) with stall_in=0 and flush=0 → st_ctrl[0] has reg_dst=1, reg_write=1, alu_op=000 after 1 edge; WB stage shows the same after 3 edges.
- LW rd=5 followed by ADD rs=5 → hazard_stall=1 for exactly one cycle; stage 0 holds a bubble; the ADD enters stage 0 on the next edge. With CTRL_LOADUSE_EN undefined → no stall.
- LW rd=0 followed by ADD rs=0 → hazard_stall stays 0.
- stall_in=1 for 3 cycles with SW in stage 1 → all stages hold; SW advances to stage 2 on the first edge after release.
- HLT in ID with flush=1 → stage 0 bubble and halted stays 0. HLT unflushed → later instructions bubble and halted=1 exactly 3 edges after HLT is in ID.
- rst_n pulled low asynchronously with LHB in stage 1 → all outputs read 0 before the next clock edge.
